// File: rtl/input_port_buf_pkg.sv
// Shared router package: direction encoding used by the input buffers and
// the switch allocator, plus the input-buffer occupancy state encoding.
//   DIR_NONE  (0) : no request / no grant
//   DIR_LOCAL (1) .. DIR_WEST (5) : output directions; 6 and 7 unused
package input_port_buf_pkg;

    localparam int unsigned DIR_W = 3;

    typedef enum logic [DIR_W-1:0] {
        DIR_NONE  = 3'd0,
        DIR_LOCAL = 3'd1,
        DIR_NORTH = 3'd2,
        DIR_EAST  = 3'd3,
        DIR_SOUTH = 3'd4,
        DIR_WEST  = 3'd5
    } dir_e;

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_PARTIAL,
        BUF_FULL
    } buf_state_e;

endpackage

// File: rtl/input_port_buf_xy_route.sv
// xy_route: combinational dimension-ordered (X then Y) route computation.
// Ports:
//   dest_x_i / dest_y_i : destination coordinates of the flit (unsigned)
//   dir_o               : output direction for this router (never DIR_NONE)
module xy_route
    import input_port_buf_pkg::*;
#(
    parameter int unsigned COORD_W = 3,
    parameter int unsigned CUR_X   = 0,
    parameter int unsigned CUR_Y   = 0
) (
    input  logic [COORD_W-1:0] dest_x_i,
    input  logic [COORD_W-1:0] dest_y_i,
    output dir_e               dir_o
);

    localparam logic [COORD_W-1:0] CX = COORD_W'(CUR_X);
    localparam logic [COORD_W-1:0] CY = COORD_W'(CUR_Y);

    always_comb begin
        dir_o = DIR_LOCAL;
        if (dest_x_i > CX) begin
            dir_o = DIR_EAST;
        end else if (dest_x_i < CX) begin
            dir_o = DIR_WEST;
        end else if (dest_y_i > CY) begin
            dir_o = DIR_NORTH;
        end else if (dest_y_i < CY) begin
            dir_o = DIR_SOUTH;
        end
    end

endmodule

// File: rtl/input_port_buf.sv
// input_port_buf: router input-port FIFO. Each flit is routed (XY) as it is
// written and the 3-bit direction is stored beside it, so the head request
// is available combinationally to the allocator.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   in_valid/in_flit: upstream flit; in_ready high whenever not full
//   grant           : allocator direction for this port (0 = none)
//   targ            : requested direction of head flit (0 = empty)
//   pop             : head leaves this cycle (grant matches targ)
//   out_flit        : head flit, meaningful when targ != 0
//   occupancy       : number of stored flits (0..DEPTH)
module input_port_buf
    import input_port_buf_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned COORD_W = 3,
    parameter int unsigned CUR_X   = 0,
    parameter int unsigned CUR_Y   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_flit,
    output logic                     in_ready,
    input  logic [2:0]               grant,
    output logic [2:0]               targ,
    output logic                     pop,
    output logic [DATA_W-1:0]        out_flit,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned ENT_W = DATA_W + DIR_W;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    buf_state_e         state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [ENT_W-1:0]   mem_q [DEPTH];

    dir_e               in_dir;
    dir_e               head_dir;
    logic               push;

    xy_route #(
        .COORD_W (COORD_W),
        .CUR_X   (CUR_X),
        .CUR_Y   (CUR_Y)
    ) u_route (
        .dest_x_i (in_flit[COORD_W-1:0]),
        .dest_y_i (in_flit[2*COORD_W-1:COORD_W]),
        .dir_o    (in_dir)
    );

    // Head entry outputs; the state (not the stale entry) decides emptiness.
    always_comb begin
        head_dir  = dir_e'(mem_q[rd_ptr_q][ENT_W-1:DATA_W]);
        out_flit  = mem_q[rd_ptr_q][DATA_W-1:0];
        targ      = (state_q == BUF_EMPTY) ? DIR_NONE : head_dir;
        in_ready  = (state_q != BUF_FULL);
        push      = in_valid && in_ready;
        pop       = (targ != DIR_NONE) && (grant == targ);
        occupancy = count_q;
    end

    // Next-state: pointers, count and the EMPTY/PARTIAL/FULL state are all
    // derived from the same push/pop decision so they can never disagree.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        if (count_d == '0) begin
            state_d = BUF_EMPTY;
        end else if (count_d == FULL_CNT) begin
            state_d = BUF_FULL;
        end else begin
            state_d = BUF_PARTIAL;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= BUF_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed when non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_dir, in_flit};
        end
    end

endmodule

// File: tb/tb_input_port_buf.sv
module tb_input_port_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_flit;
    logic        in_ready;
    logic [2:0]  grant;
    logic [2:0]  targ;
    logic        pop;
    logic [31:0] out_flit;
    logic [2:0]  occupancy;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [31:0] q [$];
    logic [31:0] fa, fb, fc, fd, fe, ff;

    always #5 clk = ~clk;

    input_port_buf #(
        .DATA_W  (32),
        .DEPTH   (4),
        .COORD_W (3),
        .CUR_X   (2),
        .CUR_Y   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_flit   (in_flit),
        .in_ready  (in_ready),
        .grant     (grant),
        .targ      (targ),
        .pop       (pop),
        .out_flit  (out_flit),
        .occupancy (occupancy)
    );

    function automatic logic [31:0] mk(input logic [25:0] tag, input logic [2:0] dx, input logic [2:0] dy);
        return {tag, dy, dx};
    endfunction

    // Reference XY route for router (2,2).
    function automatic logic [2:0] xy(input logic [31:0] f);
        logic [2:0] dx, dy;
        dx = f[2:0];
        dy = f[5:3];
        if (dx > 3'd2) return 3'd3;
        if (dx < 3'd2) return 3'd5;
        if (dy > 3'd2) return 3'd2;
        if (dy < 3'd2) return 3'd4;
        return 3'd1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_flit  = '0;
        grant    = 3'd0;
        fa = mk(26'h0A, 3'd3, 3'd2);
        fb = mk(26'h0B, 3'd1, 3'd2);
        fc = mk(26'h0C, 3'd2, 3'd3);
        fd = mk(26'h0D, 3'd2, 3'd1);
        fe = mk(26'h0E, 3'd2, 3'd2);
        ff = mk(26'h0F, 3'd0, 3'd0);

        // Reset state
        tick();
        chk("rst_occ",   32'(occupancy), 32'd0);
        chk("rst_targ",  32'(targ),      32'd0);
        chk("rst_pop",   32'(pop),       32'd0);
        chk("rst_ready", 32'(in_ready),  32'd1);

        // First push at first edge after reset release; fill with no grant
        rst = 1'b1;
        in_valid = 1'b1;
        in_flit = fa;
        tick();
        chk("push1_occ",  32'(occupancy), 32'd1);
        chk("push1_targ", 32'(targ),      32'd3);
        chk("push1_flit", out_flit,       fa);
        in_flit = fb; tick();
        chk("push2_occ", 32'(occupancy), 32'd2);
        in_flit = fc; tick();
        chk("push3_occ", 32'(occupancy), 32'd3);
        in_flit = fd; tick();
        chk("push4_occ",   32'(occupancy), 32'd4);
        chk("full_ready",  32'(in_ready),  32'd0);
        chk("full_targ",   32'(targ),      32'd3);

        // Fifth flit refused while full
        in_flit = fe; tick();
        chk("push5_occ",  32'(occupancy), 32'd4);
        chk("push5_targ", 32'(targ),      32'd3);
        chk("push5_flit", out_flit,       fa);

        // Mismatched grant ignored
        grant = 3'd2;
        #1;
        chk("mism_pop", 32'(pop), 32'd0);
        tick();
        chk("mism_occ", 32'(occupancy), 32'd4);

        // Full, in_valid, matching grant: only the pop happens
        grant = 3'd3;
        #1;
        chk("fullpop_pop",   32'(pop),      32'd1);
        chk("fullpop_ready", 32'(in_ready), 32'd0);
        tick();
        chk("fullpop_occ",  32'(occupancy), 32'd3);
        chk("fullpop_targ", 32'(targ),      32'd5);
        chk("fullpop_flit", out_flit,       fb);
        grant = 3'd0;
        chk("refill_ready", 32'(in_ready), 32'd1);
        tick();
        chk("refill_occ", 32'(occupancy), 32'd4);
        in_valid = 1'b0;

        // Drain: head directions 5,2,4,1
        grant = 3'd5; #1;
        chk("drB_pop", 32'(pop), 32'd1);
        tick();
        chk("drB_occ",  32'(occupancy), 32'd3);
        chk("drC_targ", 32'(targ),      32'd2);
        chk("drC_flit", out_flit,       fc);
        grant = 3'd2; tick();
        chk("drD_targ", 32'(targ),      32'd4);
        chk("drD_flit", out_flit,       fd);
        grant = 3'd4; tick();
        chk("drE_targ", 32'(targ),      32'd1);
        chk("drE_flit", out_flit,       fe);
        chk("drE_occ",  32'(occupancy), 32'd1);
        grant = 3'd1; tick();
        chk("empty_occ",  32'(occupancy), 32'd0);
        chk("empty_targ", 32'(targ),      32'd0);

        // Grant while empty ignored
        grant = 3'd1; #1;
        chk("emptygnt_pop", 32'(pop), 32'd0);
        tick();
        chk("emptygnt_occ", 32'(occupancy), 32'd0);

        // Streaming 10 flits with matching grants (pointer wrap)
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_flit  = mk(26'(32'h100 + k), 3'(k % 4), 3'((k + 1) % 4));
            grant    = (q.size() != 0) ? xy(q[0]) : 3'd0;
            #1;
            if (q.size() != 0) begin
                chk("strm_pop",  32'(pop),  32'd1);
                chk("strm_targ", 32'(targ), 32'(xy(q[0])));
                chk("strm_flit", out_flit,  q[0]);
            end
            q.push_back(in_flit);
            tick();
            if (grant != 3'd0) void'(q.pop_front());
            chk("strm_occ", 32'(occupancy), 32'(q.size()));
        end
        in_valid = 1'b0;
        while (q.size() != 0) begin
            grant = xy(q[0]);
            #1;
            chk("strm_tail_flit", out_flit, q[0]);
            tick();
            void'(q.pop_front());
            chk("strm_tail_occ", 32'(occupancy), 32'(q.size()));
        end
        grant = 3'd0;

        // Asynchronous reset mid-operation
        in_valid = 1'b1;
        in_flit = fa; tick();
        in_flit = fb; tick();
        in_flit = fc; tick();
        in_valid = 1'b0;
        chk("pre_rst_occ", 32'(occupancy), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_occ",   32'(occupancy), 32'd0);
        chk("arst_targ",  32'(targ),      32'd0);
        chk("arst_ready", 32'(in_ready),  32'd1);
        rst = 1'b1;
        in_valid = 1'b1;
        in_flit = ff;
        tick();
        in_valid = 1'b0;
        chk("post_rst_occ",  32'(occupancy), 32'd1);
        chk("post_rst_targ", 32'(targ),      32'd5);
        chk("post_rst_flit", out_flit,       ff);
        grant = 3'd5; tick();
        grant = 3'd0;
        chk("post_rst_drain", 32'(occupancy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
